// File: rtl/intv_frame_sched.sv
// rtl/intv_frame_sched.sv - frame sequencer (SIGNAL + DATA symbols) ahead of the block interleaver
//
// Runs one frame per accepted cfg_start. The frame is one 48-bit SIGNAL symbol
// followed by cfg_n_sym DATA symbols. DATA symbols use the latched Map_Type.
// Coded bits pass through combinationally with valid/ready gating.
// The sig_flag/Map_Type sideband changes only on symbol boundaries.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   cfg_start              frame start pulse (accepted only when idle)
//   cfg_map_type[1:0]      DATA Map_Type: 00=48, 01=96, 10=192, 11=288 bits/symbol
//   cfg_n_sym[SYM_W-1:0]   number of DATA symbols (0 = SIGNAL only)
//   busy                   high from accepted start until DONE exits
//   frame_done             one-cycle pulse while in DONE
//   sym_last               registered pulse after the last bit of any symbol
//   sym_idx[SYM_W-1:0]     current DATA symbol index (0 during SIGNAL)
//   s_din/_vld/_rdy        upstream coded-bit stream
//   m_dout/_vld/_rdy       stream to the interleaver
//   m_sig_flag             1 during the SIGNAL symbol
//   m_map_type[1:0]        Map_Type of the current symbol
module intv_frame_sched #(
  parameter int SYM_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [1:0]       cfg_map_type,
  input  logic [SYM_W-1:0] cfg_n_sym,
  output logic             busy,
  output logic             frame_done,
  output logic             sym_last,
  output logic [SYM_W-1:0] sym_idx,
  input  logic             s_din,
  input  logic             s_din_vld,
  output logic             s_din_rdy,
  output logic             m_dout,
  output logic             m_dout_vld,
  input  logic             m_dout_rdy,
  output logic             m_sig_flag,
  output logic [1:0]       m_map_type
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SIG  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [8:0]       bit_cnt;
  logic [8:0]       bits_per_sym;
  logic [1:0]       map_lat;
  logic [SYM_W-1:0] nsym_lat;
  logic             act;
  logic             xfer;
  logic             last;
  logic             last_sym;
  logic             start_ok;

  // SIGNAL is always BPSK (48 bits); DATA length follows the latched Map_Type.
  always_comb begin
    bits_per_sym = 9'd48;
    if (state == ST_DATA) begin
      case (map_lat)
        2'b00:   bits_per_sym = 9'd48;
        2'b01:   bits_per_sym = 9'd96;
        2'b10:   bits_per_sym = 9'd192;
        default: bits_per_sym = 9'd288;
      endcase
    end
  end

  assign act        = (state == ST_SIG) || (state == ST_DATA);
  assign m_dout     = s_din;
  assign m_dout_vld = s_din_vld & act;
  assign s_din_rdy  = m_dout_rdy & act;
  assign xfer       = s_din_vld & s_din_rdy;
  assign last       = xfer && (bit_cnt == bits_per_sym - 9'd1);
  assign start_ok   = (state == ST_IDLE) && cfg_start;
  // Only meaningful in DATA, where nsym_lat is known to be non-zero.
  assign last_sym   = (sym_idx == nsym_lat - SYM_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cfg_start) state_nxt = ST_SIG;
      ST_SIG:  if (last) state_nxt = (nsym_lat != '0) ? ST_DATA : ST_DONE;
      ST_DATA: if (last && last_sym) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
      sym_last   <= 1'b0;
      sym_idx    <= '0;
      bit_cnt    <= '0;
      map_lat    <= '0;
      nsym_lat   <= '0;
      m_sig_flag <= 1'b0;
      m_map_type <= 2'b00;
    end else begin
      sym_last   <= last;
      frame_done <= (state_nxt == ST_DONE) && (state != ST_DONE);

      // bit_cnt only moves on transfers, which are impossible outside SIG/DATA.
      if (xfer) begin
        bit_cnt <= last ? 9'd0 : bit_cnt + 9'd1;
      end

      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            busy       <= 1'b1;
            map_lat    <= cfg_map_type;
            nsym_lat   <= cfg_n_sym;
            sym_idx    <= '0;
            bit_cnt    <= '0;
            m_sig_flag <= 1'b1;
            m_map_type <= 2'b00;
          end
        end
        ST_SIG: begin
          if (last) begin
            m_sig_flag <= 1'b0;
            if (nsym_lat != '0) begin
              m_map_type <= map_lat;
            end
          end
        end
        ST_DATA: begin
          if (last) begin
            sym_idx <= last_sym ? '0 : sym_idx + SYM_W'(1);
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          sym_idx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_intv_frame_sched.sv
// tb/tb_intv_frame_sched.sv - self-checking bench for intv_frame_sched
module tb_intv_frame_sched;

  localparam int SYM_W = 12;

  logic             clk;
  logic             rst;
  logic             cfg_start;
  logic [1:0]       cfg_map_type;
  logic [SYM_W-1:0] cfg_n_sym;
  logic             busy;
  logic             frame_done;
  logic             sym_last;
  logic [SYM_W-1:0] sym_idx;
  logic             s_din;
  logic             s_din_vld;
  logic             s_din_rdy;
  logic             m_dout;
  logic             m_dout_vld;
  logic             m_dout_rdy;
  logic             m_sig_flag;
  logic [1:0]       m_map_type;

  int checks = 0;
  int errors = 0;

  intv_frame_sched #(.SYM_W(SYM_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_map_type (cfg_map_type),
    .cfg_n_sym    (cfg_n_sym),
    .busy         (busy),
    .frame_done   (frame_done),
    .sym_last     (sym_last),
    .sym_idx      (sym_idx),
    .s_din        (s_din),
    .s_din_vld    (s_din_vld),
    .s_din_rdy    (s_din_rdy),
    .m_dout       (m_dout),
    .m_dout_vld   (m_dout_vld),
    .m_dout_rdy   (m_dout_rdy),
    .m_sig_flag   (m_sig_flag),
    .m_map_type   (m_map_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bps_of(input logic [1:0] map);
    int mult[4] = '{1, 2, 4, 6};
    return 48 * mult[map];
  endfunction

  // Frame model: bit n of the frame is SIGNAL for n < 48, else DATA symbol (n-48)/bps.
  task automatic run_frame(input logic [1:0] map, input int nsym, input int rdy_pct,
                           input int vld_pct, input int mid_start_at, input int abort_at);
    int bps, total, n, cyc, budget;
    bit exp_last;
    bps    = bps_of(map);
    total  = 48 + nsym * bps;
    budget = total * 50 + 200;

    @(posedge clk); #1;
    cfg_start    = 1'b1;
    cfg_map_type = map;
    cfg_n_sym    = nsym[SYM_W-1:0];
    s_din_vld    = 1'b0;
    @(posedge clk); #1;
    cfg_start    = 1'b0;
    cfg_map_type = 2'($urandom);
    cfg_n_sym    = SYM_W'($urandom);
    chk("start_busy", busy, 1'b1);
    chk("start_sig", m_sig_flag, 1'b1);
    chk("start_type", m_map_type, 2'b00);

    n = 0; cyc = 0; exp_last = 0;
    while (n < total && cyc < budget) begin
      cfg_start  = 1'b0;
      s_din      = 1'($urandom);
      s_din_vld  = ($urandom % 100) < vld_pct;
      m_dout_rdy = ($urandom % 100) < rdy_pct;
      if (n == mid_start_at) begin
        cfg_start    = 1'b1;
        cfg_map_type = map ^ 2'b01;
        cfg_n_sym    = SYM_W'(nsym + 3);
      end
      if (n == abort_at) begin
        rst        = 1'b1;
        s_din_vld  = 1'b1;
        m_dout_rdy = 1'b1;
        @(negedge clk);
        chk("rst_rdy", s_din_rdy, 1'b0);
        chk("rst_vld", m_dout_vld, 1'b0);
        chk("rst_idx", sym_idx, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sig", m_sig_flag, 1'b0);
        chk("rst_type", m_map_type, 2'b00);
        @(posedge clk); #1;
        rst       = 1'b0;
        s_din_vld = 1'b0;
        return;
      end
      @(negedge clk);
      chk("sym_last", sym_last, exp_last);
      chk("busy", busy, 1'b1);
      chk("rdy_gate", s_din_rdy, m_dout_rdy);
      chk("vld_gate", m_dout_vld, s_din_vld);
      exp_last = 0;
      if (s_din_vld && m_dout_rdy) begin
        chk("data", m_dout, s_din);
        chk("sig_flag", m_sig_flag, n < 48);
        chk("map_type", m_map_type, (n < 48) ? 2'b00 : map);
        chk("sym_idx", sym_idx, (n < 48) ? 0 : (n - 48) / bps);
        if (n == 47 || (n >= 48 && (n - 48) % bps == bps - 1)) exp_last = 1;
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    s_din_vld = 1'b0;
    cfg_start = 1'b0;
    chk("xfer_count", n, total);
    if (rdy_pct >= 100 && vld_pct >= 100) chk("full_rate_cycles", cyc, total);
    @(negedge clk);
    chk("end_sym_last", sym_last, exp_last);
    chk("frame_done", frame_done, 1'b1);
    chk("done_busy", busy, 1'b1);
    chk("done_idx", sym_idx, '0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_pulse", frame_done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_rdy", s_din_rdy, 1'b0);
  endtask

  initial begin
    rst          = 1'b1;
    cfg_start    = 1'b0;
    cfg_map_type = 2'b00;
    cfg_n_sym    = '0;
    s_din        = 1'b0;
    s_din_vld    = 1'b0;
    m_dout_rdy   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_last", sym_last, 1'b0);
    chk("rst_idx", sym_idx, '0);
    chk("rst_sig", m_sig_flag, 1'b0);
    chk("rst_type", m_map_type, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;

    // Idle gating: upstream valid must not be consumed while idle.
    s_din_vld  = 1'b1;
    m_dout_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_rdy", s_din_rdy, 1'b0);
      chk("idle_vld", m_dout_vld, 1'b0);
    end
    s_din_vld = 1'b0;

    // SIGNAL only, full rate.
    run_frame(2'b00, 0, 100, 100, -1, -1);
    // Mixed: two DATA symbols of 192 bits.
    run_frame(2'b10, 2, 100, 100, -1, -1);
    // Backpressure on the interleaver side.
    run_frame(2'b11, 1, 50, 100, -1, -1);
    // Start while busy, mid-DATA.
    run_frame(2'b01, 3, 80, 80, 48 + 96 + 10, -1);
    // Reset at bit 100 of DATA symbol 1, then a clean frame.
    run_frame(2'b11, 3, 100, 100, -1, 48 + 288 + 100);
    run_frame(2'b00, 2, 100, 100, -1, -1);
    // Randomized frames.
    for (int f = 0; f < 6; f++) begin
      run_frame(2'($urandom), int'($urandom_range(0, 4)),
                int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
